// File: rtl/smac_pipe.sv
//----------------------------------------------------------------------------
// smac_pipe -- pipelined lane-parallel signed multiply-add
//
// res_mac_n = data_input * weight + res_mac_p, evaluated independently per
// lane. The lane width (8/16/32 bits) is chosen per beat by select_precision
// and travels with the beat, so consecutive beats may use different widths.
// A valid/ready handshake lets the block sit in a stallable MAC chain.
//
// Optional build macro:
//   SMAC_SAT_EN  defined   -> each lane result clamps to its signed range
//                undefined -> lane results wrap (two's complement)
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   ce               clock enable, low freezes every pipeline stage
//   sclr             synchronous clear, wins over ce, drops in-flight beats
//   in_valid         input beat valid
//   in_ready         input beat accepted this cycle when in_valid is high
//   select_precision lane mode: 00 INT8, 01 INT16, 10 INT32, 11 reserved
//   data_input       activation lanes
//   weight           weight lanes
//   res_mac_p        partial-sum lanes from the previous MAC
//   out_valid        output beat valid
//   out_ready        downstream accepts the output beat
//   res_mac_n        result lanes (zero for a reserved-mode beat)
//   out_prec         lane mode of the output beat
//   err_prec         sticky: a reserved-mode beat was accepted
//----------------------------------------------------------------------------
module smac_pipe #(
   parameter int DATA_W = 64,
   parameter int LAT    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic              sclr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        select_precision,
   input  logic [DATA_W-1:0] data_input,
   input  logic [DATA_W-1:0] weight,
   input  logic [DATA_W-1:0] res_mac_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] res_mac_n,
   output logic [1:0]        out_prec,
   output logic              err_prec
);

   localparam int PW = 2 * DATA_W;   // product vector: every lane doubles in width

   localparam logic [1:0] P8   = 2'b00;
   localparam logic [1:0] P16  = 2'b01;
   localparam logic [1:0] P32  = 2'b10;
   localparam logic [1:0] PRSV = 2'b11;

   // Full-precision signed lane products
   function automatic logic [15:0] mul8(input logic signed [7:0] a, input logic signed [7:0] b);
      logic signed [15:0] ea, eb;
      ea = 16'(a);
      eb = 16'(b);
      return ea * eb;
   endfunction

   function automatic logic [31:0] mul16(input logic signed [15:0] a, input logic signed [15:0] b);
      logic signed [31:0] ea, eb;
      ea = 32'(a);
      eb = 32'(b);
      return ea * eb;
   endfunction

   function automatic logic [63:0] mul32(input logic signed [31:0] a, input logic signed [31:0] b);
      logic signed [63:0] ea, eb;
      ea = 64'(a);
      eb = 64'(b);
      return ea * eb;
   endfunction

   // Fit a wide lane sum into a w-bit lane; the caller keeps the low w bits.
   function automatic logic [31:0] lane_fit(input logic signed [64:0] v, input int w);
`ifdef SMAC_SAT_EN
      logic signed [64:0] hi, lo;
      hi = (65'sd1 <<< (w - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (w - 1));
      if (v > hi) return hi[31:0];
      if (v < lo) return lo[31:0];
      return v[31:0];
`else
      logic [31:0] m;
      m = (w >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << w) - 64'd1);
      return v[31:0] & m;
`endif
   endfunction

   logic advance, accept;

   // S1 (_p0): operands and tag
   logic              vld_p0;
   logic [1:0]        prec_p0;
   logic [DATA_W-1:0] a_p0, b_p0, c_p0;
   // S2 (_p1): lane products
   logic              vld_p1;
   logic [1:0]        prec_p1;
   logic [PW-1:0]     prod_p1;
   logic [DATA_W-1:0] c_p1;
   // S3 (_p2): lane sums, drive the outputs
   logic              vld_p2;
   logic [1:0]        prec_p2;
   logic [DATA_W-1:0] res_p2;
   logic              err_p;

   logic [PW-1:0]     prod_d;
   logic [DATA_W-1:0] sum_d;
   logic [LAT-1:0]    vld_vec;

   // The whole pipe moves as one; a full S3 that is not taken stalls everything.
   assign advance  = ce & (~vld_p2 | out_ready);
   assign in_ready = advance & rst_n;
   assign accept   = in_valid & in_ready;

   //---------------------------------------------------------------- S1 -> S2
   always_comb begin
      prod_d = '0;
      case (prec_p0)
         P8:  for (int k = 0; k < DATA_W / 8; k++)
                 prod_d[k*16 +: 16] = mul8(a_p0[k*8 +: 8], b_p0[k*8 +: 8]);
         P16: for (int k = 0; k < DATA_W / 16; k++)
                 prod_d[k*32 +: 32] = mul16(a_p0[k*16 +: 16], b_p0[k*16 +: 16]);
         P32: for (int k = 0; k < DATA_W / 32; k++)
                 prod_d[k*64 +: 64] = mul32(a_p0[k*32 +: 32], b_p0[k*32 +: 32]);
         default: prod_d = '0;
      endcase
   end

   //---------------------------------------------------------------- S2 -> S3
   always_comb begin
      logic signed [64:0] full;
      logic [31:0]        fit;
      full  = '0;
      fit   = '0;
      sum_d = '0;
      case (prec_p1)
         P8:  for (int k = 0; k < DATA_W / 8; k++) begin
                 full = 65'($signed(prod_p1[k*16 +: 16])) + 65'($signed(c_p1[k*8 +: 8]));
                 fit  = lane_fit(full, 8);
                 sum_d[k*8 +: 8] = fit[7:0];
              end
         P16: for (int k = 0; k < DATA_W / 16; k++) begin
                 full = 65'($signed(prod_p1[k*32 +: 32])) + 65'($signed(c_p1[k*16 +: 16]));
                 fit  = lane_fit(full, 16);
                 sum_d[k*16 +: 16] = fit[15:0];
              end
         P32: for (int k = 0; k < DATA_W / 32; k++) begin
                 full = 65'($signed(prod_p1[k*64 +: 64])) + 65'($signed(c_p1[k*32 +: 32]));
                 fit  = lane_fit(full, 32);
                 sum_d[k*32 +: 32] = fit;
              end
         default: sum_d = '0;   // reserved mode yields an all-zero result
      endcase
   end

   // Control, tags and the visible result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         prec_p0 <= 2'b00;
         prec_p1 <= 2'b00;
         prec_p2 <= 2'b00;
         res_p2  <= '0;
         err_p   <= 1'b0;
      end else if (sclr) begin
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         prec_p0 <= 2'b00;
         prec_p1 <= 2'b00;
         prec_p2 <= 2'b00;
         res_p2  <= '0;
         err_p   <= 1'b0;
      end else begin
         if (accept && select_precision == PRSV)
            err_p <= 1'b1;
         if (advance) begin
            vld_p0  <= accept;   // no accept -> bubble enters S1
            vld_p1  <= vld_p0;
            vld_p2  <= vld_p1;
            prec_p0 <= select_precision;
            prec_p1 <= prec_p0;
            prec_p2 <= prec_p1;
            res_p2  <= sum_d;
         end
      end
   end

   // Internal datapath registers carry no reset; their valid bits qualify them.
   always_ff @(posedge clk) begin
      if (advance) begin
         a_p0    <= data_input;
         b_p0    <= weight;
         c_p0    <= res_mac_p;
         prod_p1 <= prod_d;
         c_p1    <= c_p0;
      end
   end

   assign vld_vec   = {vld_p2, vld_p1, vld_p0};
   assign out_valid = vld_vec[LAT-1];
   assign res_mac_n = res_p2;
   assign out_prec  = prec_p2;
   assign err_prec  = err_p;

endmodule

// File: tb/tb_smac_pipe.sv
//----------------------------------------------------------------------------
// tb_smac_pipe -- directed self-checking bench for smac_pipe (DATA_W = 64)
// Expected values are hand-computed; SMAC_SAT_EN selects the clamped set.
//----------------------------------------------------------------------------
module tb_smac_pipe;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ce;
   logic          sclr;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    select_precision;
   logic [DW-1:0] data_input;
   logic [DW-1:0] weight;
   logic [DW-1:0] res_mac_p;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] res_mac_n;
   logic [1:0]    out_prec;
   logic          err_prec;

   int n_chk = 0;
   int n_err = 0;

   logic [63:0] got_res[$];
   logic [1:0]  got_prec[$];

   smac_pipe #(.DATA_W(DW), .LAT(3)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr),
      .in_valid(in_valid), .in_ready(in_ready),
      .select_precision(select_precision),
      .data_input(data_input), .weight(weight), .res_mac_p(res_mac_p),
      .out_valid(out_valid), .out_ready(out_ready),
      .res_mac_n(res_mac_n), .out_prec(out_prec), .err_prec(err_prec)
   );

   always #5 clk = ~clk;

   // Record every output transfer
   always @(posedge clk) begin
      if (rst_n && !sclr && ce && out_valid && out_ready) begin
         got_res.push_back(res_mac_n);
         got_prec.push_back(out_prec);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] p,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      in_valid         = v;
      select_precision = p;
      data_input       = a;
      weight           = b;
      res_mac_p        = c;
   endtask

`ifdef SMAC_SAT_EN
   localparam logic [63:0] EXP_OVF8 = 64'h0000_0000_0000_807F;
   localparam logic [63:0] EXP_I16  = 64'h0000_0000_7FFF_0003;
   localparam logic [63:0] EXP_I32  = 64'hFFFF_FFFA_7FFF_FFFF;
`else
   localparam logic [63:0] EXP_OVF8 = 64'h0000_0000_0000_FFFE;
   localparam logic [63:0] EXP_I16  = 64'h0000_0000_0000_0003;
   localparam logic [63:0] EXP_I32  = 64'hFFFF_FFFA_0000_0001;
`endif

   initial begin
      int base;
      int idx;
      logic acc;

      rst_n = 1'b0;
      ce = 1'b1;
      sclr = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 2'b00, '0, '0, '0);

      // Reset state
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_res",       res_mac_n,      64'd0);
      check("rst_out_prec",  64'(out_prec),  64'd0);
      check("rst_err",       64'(err_prec),  64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("run_in_ready", 64'(in_ready), 64'd1);

      // INT8 basic, latency 3
      drive(1'b1, 2'b00, 64'h0000_0000_0000_FD05, 64'h0000_0000_0000_0403, 64'h0000_0000_0000_0102);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      check("i8_lat_e0", 64'(out_valid), 64'd0);
      tick();
      check("i8_lat_e1", 64'(out_valid), 64'd0);
      tick();
      check("i8_valid", 64'(out_valid), 64'd1);
      check("i8_res",   res_mac_n,      64'h0000_0000_0000_F511);
      check("i8_prec",  64'(out_prec),  64'd0);
      tick();

      // INT8 overflow
      drive(1'b1, 2'b00, 64'h0000_0000_0000_807F, 64'h0000_0000_0000_0202, 64'h0000_0000_0000_FF00);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      tick();
      tick();
      check("ovf8_valid", 64'(out_valid), 64'd1);
      check("ovf8_res",   res_mac_n,      EXP_OVF8);
      tick();

      // INT16 then INT32 back to back
      drive(1'b1, 2'b01, 64'h0000_0000_8000_FFFF, 64'h0000_0000_8000_0002, 64'h0000_0000_0000_0005);
      tick();
      drive(1'b1, 2'b10, 64'hFFFF_FFFE_0001_0000, 64'h0000_0003_0001_0000, 64'h0000_0000_0000_0001);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      tick();
      check("i16_valid", 64'(out_valid), 64'd1);
      check("i16_res",   res_mac_n,      EXP_I16);
      check("i16_prec",  64'(out_prec),  64'd1);
      tick();
      check("i32_valid", 64'(out_valid), 64'd1);
      check("i32_res",   res_mac_n,      EXP_I32);
      check("i32_prec",  64'(out_prec),  64'd2);
      tick();
      check("b2b_drain", 64'(out_valid), 64'd0);

      // Backpressure: 6 beats, out_ready low for 5 cycles
      base = got_res.size();
      idx = 0;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         out_ready = (c >= 5);
         drive(1'b1, 2'b00, 64'(idx + 1), 64'h01, 64'h10);
         #1;
         if (c < 3)
            check("bp_rdy_open", 64'(in_ready), 64'd1);
         else if (c < 5) begin
            check("bp_rdy_stall", 64'(in_ready), 64'd0);
            check("bp_hold_vld",  64'(out_valid), 64'd1);
            check("bp_hold_res",  res_mac_n, 64'h11);
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) idx++;
      end
      check("bp_all_accepted", 64'(idx), 64'd6);
      drive(1'b0, 2'b00, '0, '0, '0);
      out_ready = 1'b1;
      for (int t = 0; t < 12 && got_res.size() < base + 6; t++) tick();
      tick();
      tick();
      check("bp_count", 64'(got_res.size() - base), 64'd6);
      if (got_res.size() >= base + 6)
         for (int i = 0; i < 6; i++)
            check("bp_order", got_res[base + i], 64'(8'h11 + i));

      // ce low for 4 cycles mid-stream
      base = got_res.size();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'b01, 64'(i + 2), 64'h3, 64'h0);
         tick();
      end
      ce = 1'b0;
      drive(1'b1, 2'b01, 64'h7, 64'h3, 64'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("ce_in_ready", 64'(in_ready),  64'd0);
         check("ce_hold_vld", 64'(out_valid), 64'd1);
         check("ce_hold_res", res_mac_n,      64'h6);
         tick();
      end
      ce = 1'b1;
      drive(1'b0, 2'b00, '0, '0, '0);
      for (int t = 0; t < 12 && got_res.size() < base + 3; t++) tick();
      tick();
      tick();
      check("ce_count", 64'(got_res.size() - base), 64'd3);
      if (got_res.size() >= base + 3) begin
         check("ce_r0", got_res[base],     64'h6);
         check("ce_r1", got_res[base + 1], 64'h9);
         check("ce_r2", got_res[base + 2], 64'hC);
         check("ce_p0", 64'(got_prec[base]), 64'd1);
      end

      // sclr with two beats in flight, plus a same-cycle beat
      base = got_res.size();
      drive(1'b1, 2'b00, 64'h55, 64'h1, 64'h0);
      tick();
      drive(1'b1, 2'b00, 64'h66, 64'h1, 64'h0);
      tick();
      sclr = 1'b1;
      drive(1'b1, 2'b00, 64'h77, 64'h1, 64'h0);
      tick();
      sclr = 1'b0;
      drive(1'b0, 2'b00, '0, '0, '0);
      check("sclr_vld",  64'(out_valid), 64'd0);
      check("sclr_res",  res_mac_n,      64'd0);
      for (int t = 0; t < 6; t++) tick();
      check("sclr_dropped", 64'(got_res.size() - base), 64'd0);

      // Reserved precision code
      check("rsv_err_pre", 64'(err_prec), 64'd0);
      drive(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7F7F_7F7F_7F7F_7F7F, 64'h123);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      check("rsv_err_set", 64'(err_prec), 64'd1);
      tick();
      tick();
      check("rsv_valid", 64'(out_valid), 64'd1);
      check("rsv_res",   res_mac_n,      64'd0);
      check("rsv_prec",  64'(out_prec),  64'd3);
      for (int t = 0; t < 3; t++) tick();
      check("rsv_err_hold", 64'(err_prec), 64'd1);
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      check("rsv_err_clr", 64'(err_prec), 64'd0);

      // Asynchronous reset mid-stream
      base = got_res.size();
      drive(1'b1, 2'b11, 64'h1, 64'h1, 64'h1);
      tick();
      drive(1'b1, 2'b00, 64'h2, 64'h2, 64'h0);
      tick();
      drive(1'b0, 2'b00, '0, '0, '0);
      tick();
      check("arst_pre_vld", 64'(out_valid), 64'd1);
      check("arst_pre_err", 64'(err_prec),  64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_vld",   64'(out_valid), 64'd0);
      check("arst_err",   64'(err_prec),  64'd0);
      check("arst_res",   res_mac_n,      64'd0);
      check("arst_rdy",   64'(in_ready),  64'd0);
      check("arst_prec",  64'(out_prec),  64'd0);
      tick();
      rst_n = 1'b1;
      for (int t = 0; t < 5; t++) tick();
      check("arst_flushed", 64'(got_res.size() - base), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
